alu_result_collector: RTL and testbench
=======================================

Name: alu_result_collector

Overview:
- Receiving end of the ALU result interface: captures each completed ALU result (FUNC_CODE, VALUE1:VALUE0, OVERFLOW, INVALID) on a valid/ready handshake.
- Buffers results in a small FIFO and drains them to the writeback or consumer stage over a second valid/ready handshake.
- Maintains sticky OVERFLOW/INVALID status and a saturating error counter for the control/status path.
- Sits between the combinational ALU and the register-file writeback.

Parameters:
- DATA_W, 16, width of VALUE0 and VALUE1.
- FUNC_W, 4, width of FUNC_CODE.
- DEPTH, 4, FIFO entries; any value 2..16, power of two not required.
- ERRCNT_W, 8, width of ERR_COUNT.

Ports:
- CLK  in  1  clock; rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  ALU result valid.
- IN_READY  out  1  collector can accept a result.
- FUNC_CODE  in  FUNC_W  opcode that produced the result.
- VALUE0  in  DATA_W  low result word.
- VALUE1  in  DATA_W  high result word (MUL high half / DIV remainder).
- OVERFLOW  in  1  ALU overflow flag.
- INVALID  in  1  ALU invalid flag (e.g. divide by zero, undefined opcode).
- OUT_VALID  out  1  head entry valid.
- OUT_READY  in  1  consumer accepts head.
- OUT_FUNC_CODE  out  FUNC_W  head opcode.
- OUT_VALUE0  out  DATA_W  head low word.
- OUT_VALUE1  out  DATA_W  head high word.
- OUT_OVERFLOW  out  1  head overflow flag.
- OUT_INVALID  out  1  head invalid flag.
- COUNT  out  $clog2(DEPTH+1)  current occupancy.
- STICKY_OVERFLOW  out  1  set by any accepted result with OVERFLOW=1.
- STICKY_INVALID  out  1  set by any accepted result with INVALID=1.
- CLR_STICKY  in  1  synchronous clear of both sticky flags.
- ERR_COUNT  out  ERRCNT_W  accepted results with OVERFLOW|INVALID; saturates.

Behaviour:
- Reset (RST_N low, asynchronous): pointers, COUNT, sticky flags and ERR_COUNT clear to 0; OUT_VALID=0; OUT_* data=0. IN_READY=1, since it is derived from COUNT=0.
- Push occurs when IN_VALID && IN_READY. The full entry {FUNC_CODE, VALUE1, VALUE0, OVERFLOW, INVALID} is written at the write pointer.
- Pop occurs when OUT_VALID && OUT_READY. The read pointer advances.
- IN_READY = (COUNT != DEPTH), combinational from registered state only.
- OUT_VALID = (COUNT != 0). OUT_* reflect the head entry combinationally from storage; they hold 0 when empty.
- Latency: an entry pushed at edge N is visible at OUT_* with OUT_VALID=1 after edge N, i.e. one cycle. There is no same-cycle bypass.
- Push and pop in the same cycle: COUNT is unchanged and both pointers advance.
- Full: no push, even if a pop happens in the same cycle. IN_READY was already 0.
- Empty: pop is impossible. A push while empty makes OUT_VALID=1 on the next cycle.
- Pointer wrap: a pointer equal to DEPTH-1 goes to 0 on advance. Wrap must be correct for non-power-of-two DEPTH.
- Input stability: FUNC_CODE, VALUE*, OVERFLOW and INVALID are sampled only on push. They are don't-care otherwise.
- Sticky flags:
  - Set on push when the corresponding input flag is 1.
  - CLR_STICKY=1 clears them on the next edge.
  - If clear and set occur in the same cycle, set wins.
- ERR_COUNT: increments by 1 on a push with OVERFLOW|INVALID. It holds at 2^ERRCNT_W-1. It is not cleared by CLR_STICKY; only reset clears it.
- Mid-operation reset: contents are discarded and OUT_VALID drops immediately (asynchronously).
- No state machine beyond FIFO occupancy. Storage uses flops, not inferred RAM.

Decomposition:
- Shared package alu_pkg:
  - FUNC_W and DATA_W constants.
  - Opcode constants: ADD=1111, SUB=1110, MUL=0001, DIV=0010, ROL=1000, ROR=1001, LSR=1010, LSL=1011.
  - Result-entry typedef {func, value1, value0, ovf, inv}.
- One sub-module, alu_res_fifo: a generic DEPTH x width flop FIFO with count, push/pop, and wrap logic.
- The top level adds the handshake mapping, sticky flags and ERR_COUNT.

Test Plan:
- Single ADD result: FUNC=1111, V1=0000, V0=8000, OVF=1, INV=0, pushed with OUT_READY=0 -> next cycle OUT_VALID=1, OUT_VALUE0=8000, OUT_OVERFLOW=1, STICKY_OVERFLOW=1, ERR_COUNT=1, COUNT=1.
- Fill to DEPTH=4 with MUL results V0=0001..0004, OUT_READY=0 -> IN_READY=0 at COUNT=4. A fifth IN_VALID is ignored. Drain yields 0001,0002,0003,0004 in order, then OUT_VALID=0.
- Continuous IN_VALID=1 and OUT_READY=1 for 10 DIV results -> COUNT stays 1 after the first, pointers wrap, and output order matches input.
- DIV by zero (FUNC=0010, INV=1) with CLR_STICKY=1 in the same cycle -> STICKY_INVALID=1 (set wins). CLR_STICKY alone next cycle -> 0. ERR_COUNT unchanged by the clear.
- ERRCNT_W=2: push 5 results with OVF=1 -> ERR_COUNT saturates at 3.
- With 3 entries held, assert RST_N=0 mid-cycle -> OUT_VALID=0 and COUNT=0 immediately, IN_READY=1. After release, the first push appears after one cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU result-interface definitions: widths, opcodes and the result-entry layout.
package alu_pkg;

    localparam int FUNC_W = 4;
    localparam int DATA_W = 16;

    typedef enum logic [FUNC_W-1:0] {
        OP_MUL = 4'b0001,
        OP_DIV = 4'b0010,
        OP_ROL = 4'b1000,
        OP_ROR = 4'b1001,
        OP_LSR = 4'b1010,
        OP_LSL = 4'b1011,
        OP_SUB = 4'b1110,
        OP_ADD = 4'b1111
    } alu_op_e;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [DATA_W-1:0] value1;
        logic [DATA_W-1:0] value0;
        logic              ovf;
        logic              inv;
    } alu_entry_t;

    // Packed entry width for arbitrary FUNC/DATA widths; matches alu_entry_t at defaults.
    function automatic int entry_w(input int fw, input int dw);
        return fw + 2 * dw + 2;
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Generic DEPTH x WIDTH flop FIFO with occupancy count; head is zero when empty.
module alu_res_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/alu_result_collector.sv
// Collects ALU results into a small FIFO toward writeback; keeps sticky error flags and a saturating error count.
module alu_result_collector #(
    parameter int DATA_W   = 16,
    parameter int FUNC_W   = 4,
    parameter int DEPTH    = 4,
    parameter int ERRCNT_W = 8,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [FUNC_W-1:0]   FUNC_CODE,
    input  logic [DATA_W-1:0]   VALUE0,
    input  logic [DATA_W-1:0]   VALUE1,
    input  logic                OVERFLOW,
    input  logic                INVALID,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [FUNC_W-1:0]   OUT_FUNC_CODE,
    output logic [DATA_W-1:0]   OUT_VALUE0,
    output logic [DATA_W-1:0]   OUT_VALUE1,
    output logic                OUT_OVERFLOW,
    output logic                OUT_INVALID,
    output logic [CNT_W-1:0]    COUNT,
    output logic                STICKY_OVERFLOW,
    output logic                STICKY_INVALID,
    input  logic                CLR_STICKY,
    output logic [ERRCNT_W-1:0] ERR_COUNT
);

    import alu_pkg::*;

    localparam int ENTRY_W = entry_w(FUNC_W, DATA_W);

    logic [ENTRY_W-1:0]  w_in_entry;
    logic [ENTRY_W-1:0]  w_head;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                r_sticky_ovf;
    logic                r_sticky_inv;
    logic [ERRCNT_W-1:0] r_err_count;

    assign w_in_entry = {FUNC_CODE, VALUE1, VALUE0, OVERFLOW, INVALID};
    assign IN_READY   = !w_full;
    assign OUT_VALID  = !w_empty;
    assign w_push     = IN_VALID && IN_READY;
    assign w_pop      = OUT_VALID && OUT_READY;

    alu_res_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_in_entry),
        .o_data  (w_head),
        .o_count (COUNT),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {OUT_FUNC_CODE, OUT_VALUE1, OUT_VALUE0, OUT_OVERFLOW, OUT_INVALID} = w_head;

    // A flagged push in the same cycle as CLR_STICKY leaves the flag set.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sticky_ovf <= 1'b0;
            r_sticky_inv <= 1'b0;
            r_err_count  <= '0;
        end else begin
            if (w_push && OVERFLOW)  r_sticky_ovf <= 1'b1;
            else if (CLR_STICKY)     r_sticky_ovf <= 1'b0;
            if (w_push && INVALID)   r_sticky_inv <= 1'b1;
            else if (CLR_STICKY)     r_sticky_inv <= 1'b0;
            if (w_push && (OVERFLOW || INVALID) && (r_err_count != '1))
                r_err_count <= r_err_count + 1'b1;
        end
    end

    assign STICKY_OVERFLOW = r_sticky_ovf;
    assign STICKY_INVALID  = r_sticky_inv;
    assign ERR_COUNT       = r_err_count;

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: default instance plus a 2-bit error-counter instance.
module tb_alu_result_collector;

    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RST_N;

    logic          IN_VALID, IN_READY, OVERFLOW, INVALID;
    logic [3:0]    FUNC_CODE;
    logic [15:0]   VALUE0, VALUE1;
    logic          OUT_VALID, OUT_READY, OUT_OVERFLOW, OUT_INVALID;
    logic [3:0]    OUT_FUNC_CODE;
    logic [15:0]   OUT_VALUE0, OUT_VALUE1;
    logic [CW-1:0] COUNT;
    logic          STICKY_OVERFLOW, STICKY_INVALID, CLR_STICKY;
    logic [7:0]    ERR_COUNT;

    logic          IN_VALID_b, IN_READY_b, OVERFLOW_b, INVALID_b;
    logic [3:0]    FUNC_CODE_b;
    logic [15:0]   VALUE0_b, VALUE1_b;
    logic          OUT_VALID_b, OUT_READY_b, OUT_OVERFLOW_b, OUT_INVALID_b;
    logic [3:0]    OUT_FUNC_CODE_b;
    logic [15:0]   OUT_VALUE0_b, OUT_VALUE1_b;
    logic [CW-1:0] COUNT_b;
    logic          STICKY_OVERFLOW_b, STICKY_INVALID_b, CLR_STICKY_b;
    logic [1:0]    ERR_COUNT_b;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_err  = 0;
    alu_entry_t exp_q[$];

    always #5 CLK = ~CLK;

    alu_result_collector #(.DATA_W(16), .FUNC_W(4), .DEPTH(DEPTH), .ERRCNT_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .FUNC_CODE(FUNC_CODE), .VALUE0(VALUE0), .VALUE1(VALUE1),
        .OVERFLOW(OVERFLOW), .INVALID(INVALID), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_FUNC_CODE(OUT_FUNC_CODE), .OUT_VALUE0(OUT_VALUE0), .OUT_VALUE1(OUT_VALUE1),
        .OUT_OVERFLOW(OUT_OVERFLOW), .OUT_INVALID(OUT_INVALID), .COUNT(COUNT),
        .STICKY_OVERFLOW(STICKY_OVERFLOW), .STICKY_INVALID(STICKY_INVALID),
        .CLR_STICKY(CLR_STICKY), .ERR_COUNT(ERR_COUNT)
    );

    alu_result_collector #(.DATA_W(16), .FUNC_W(4), .DEPTH(DEPTH), .ERRCNT_W(2)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID_b), .IN_READY(IN_READY_b),
        .FUNC_CODE(FUNC_CODE_b), .VALUE0(VALUE0_b), .VALUE1(VALUE1_b),
        .OVERFLOW(OVERFLOW_b), .INVALID(INVALID_b), .OUT_VALID(OUT_VALID_b), .OUT_READY(OUT_READY_b),
        .OUT_FUNC_CODE(OUT_FUNC_CODE_b), .OUT_VALUE0(OUT_VALUE0_b), .OUT_VALUE1(OUT_VALUE1_b),
        .OUT_OVERFLOW(OUT_OVERFLOW_b), .OUT_INVALID(OUT_INVALID_b), .COUNT(COUNT_b),
        .STICKY_OVERFLOW(STICKY_OVERFLOW_b), .STICKY_INVALID(STICKY_INVALID_b),
        .CLR_STICKY(CLR_STICKY_b), .ERR_COUNT(ERR_COUNT_b)
    );

    function automatic alu_entry_t head();
        return '{OUT_FUNC_CODE, OUT_VALUE1, OUT_VALUE0, OUT_OVERFLOW, OUT_INVALID};
    endfunction

    task automatic drive(input logic v, input logic [3:0] f, input logic [15:0] v1,
                         input logic [15:0] v0, input logic ovf, input logic inv);
        IN_VALID = v; FUNC_CODE = f; VALUE1 = v1; VALUE0 = v0; OVERFLOW = ovf; INVALID = inv;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Samples handshakes at the falling edge; queues pushed entries, pops the expected head.
    task automatic sample(output bit push, output bit pop, output bit have,
                          output alu_entry_t e, output int cnt);
        @(negedge CLK);
        push = IN_VALID && IN_READY;
        pop  = OUT_VALID && OUT_READY;
        cnt  = exp_q.size();
        have = 1'b0;
        e    = '0;
        if (pop && exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            have = 1'b1;
        end
        if (push) begin
            exp_q.push_back('{FUNC_CODE, VALUE1, VALUE0, OVERFLOW, INVALID});
            if ((OVERFLOW || INVALID) && exp_err < 255) exp_err++;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        drive(0, 4'h0, 16'h0, 16'h0, 0, 0);
        OUT_READY = 0; CLR_STICKY = 0;
        IN_VALID_b = 0; FUNC_CODE_b = '0; VALUE0_b = '0; VALUE1_b = '0;
        OVERFLOW_b = 0; INVALID_b = 0; OUT_READY_b = 0; CLR_STICKY_b = 0;
        #12;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", OUT_VALID); end
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", IN_READY); end
        n_checks++; if (COUNT !== '0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", COUNT); end
        n_checks++; if ({STICKY_OVERFLOW, STICKY_INVALID} !== 2'b00) begin n_fail++; $display("FAIL rst_sticky: got %b expected 00", {STICKY_OVERFLOW, STICKY_INVALID}); end
        n_checks++; if (ERR_COUNT !== 8'd0) begin n_fail++; $display("FAIL rst_err_count: got %0d expected 0", ERR_COUNT); end
        n_checks++; if (head() !== alu_entry_t'('0)) begin n_fail++; $display("FAIL rst_out_data: got %0h expected 0", head()); end
        n_checks++; if (ERR_COUNT_b !== 2'd0) begin n_fail++; $display("FAIL rst_err_count_sat: got %0d expected 0", ERR_COUNT_b); end
        #5 RST_N = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        bit push, pop, have; alu_entry_t e; int cnt;
        OUT_READY = 0;
        drive(1, OP_ADD, 16'h0000, 16'h8000, 1, 0);
        sample(push, pop, have, e, cnt);
        n_checks++; if (!push) begin n_fail++; $display("FAIL add_accept: got in_ready %b expected 1", IN_READY); end
        tick();
        drive(0, 4'h0, 16'h0, 16'h0, 0, 0);
        sample(push, pop, have, e, cnt);
        n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL add_out_valid: got %b expected 1", OUT_VALID); end
        n_checks++; if (OUT_VALUE0 !== 16'h8000) begin n_fail++; $display("FAIL add_value0: got %h expected 8000", OUT_VALUE0); end
        n_checks++; if (OUT_FUNC_CODE !== 4'b1111) begin n_fail++; $display("FAIL add_func: got %b expected 1111", OUT_FUNC_CODE); end
        n_checks++; if (OUT_OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL add_out_ovf: got %b expected 1", OUT_OVERFLOW); end
        n_checks++; if (STICKY_OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL add_sticky_ovf: got %b expected 1", STICKY_OVERFLOW); end
        n_checks++; if (ERR_COUNT !== 8'd1) begin n_fail++; $display("FAIL add_err_count: got %0d expected 1", ERR_COUNT); end
        n_checks++; if (COUNT !== CW'(1)) begin n_fail++; $display("FAIL add_count: got %0d expected 1", COUNT); end
        tick();
        OUT_READY = 1;
        sample(push, pop, have, e, cnt);
        n_checks++; if (!pop || !have || head() !== e) begin n_fail++; $display("FAIL add_drain: got %0h expected %0h", head(), e); end
        tick();
        OUT_READY = 0;
        sample(push, pop, have, e, cnt);
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL add_empty_after: got %b expected 0", OUT_VALID); end
        tick();
    endtask

    task automatic test_fill();
        bit push, pop, have; alu_entry_t e; int cnt;
        OUT_READY = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, OP_MUL, 16'h0000, 16'(i), 0, 0);
            sample(push, pop, have, e, cnt);
            n_checks++; if (!push) begin n_fail++; $display("FAIL fill_accept_%0d: got in_ready %b expected 1", i, IN_READY); end
            tick();
        end
        drive(1, OP_MUL, 16'h0000, 16'h0005, 0, 0);
        sample(push, pop, have, e, cnt);
        n_checks++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", IN_READY); end
        n_checks++; if (COUNT !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", COUNT, DEPTH); end
        tick();
        drive(0, 4'h0, 16'h0, 16'h0, 0, 0);
        OUT_READY = 1;
        for (int i = 1; i <= DEPTH; i++) begin
            sample(push, pop, have, e, cnt);
            n_checks++; if (!pop || !have || head() !== e) begin n_fail++; $display("FAIL drain_entry_%0d: got %0h expected %0h", i, head(), e); end
            n_checks++; if (OUT_VALUE0 !== 16'(i)) begin n_fail++; $display("FAIL drain_order_%0d: got %h expected %h", i, OUT_VALUE0, 16'(i)); end
            tick();
        end
        sample(push, pop, have, e, cnt);
        n_checks++; if (OUT_VALID !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL drain_empty: got out_valid %b expected 0 (queue %0d)", OUT_VALID, exp_q.size()); end
        OUT_READY = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit push, pop, have; alu_entry_t e; int cnt;
        OUT_READY = 1;
        for (int k = 0; k < 10; k++) begin
            drive(1, OP_DIV, 16'(k), 16'(16'h0100 + k), 0, 0);
            sample(push, pop, have, e, cnt);
            n_checks++; if (COUNT !== CW'((k == 0) ? 0 : 1)) begin n_fail++; $display("FAIL b2b_count_%0d: got %0d expected %0d", k, COUNT, (k == 0) ? 0 : 1); end
            if (k > 0) begin
                n_checks++; if (!pop || !have || head() !== e) begin n_fail++; $display("FAIL b2b_entry_%0d: got %0h expected %0h", k, head(), e); end
            end
            tick();
        end
        drive(0, 4'h0, 16'h0, 16'h0, 0, 0);
        sample(push, pop, have, e, cnt);
        n_checks++; if (!pop || !have || head() !== e) begin n_fail++; $display("FAIL b2b_last: got %0h expected %0h", head(), e); end
        tick();
        sample(push, pop, have, e, cnt);
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", OUT_VALID); end
        tick();
    endtask

    task automatic test_sticky();
        bit push, pop, have; alu_entry_t e; int cnt;
        OUT_READY = 1;
        drive(1, OP_DIV, 16'h0000, 16'h0000, 0, 1);
        CLR_STICKY = 1;
        sample(push, pop, have, e, cnt);
        tick();
        drive(0, 4'h0, 16'h0, 16'h0, 0, 0);
        sample(push, pop, have, e, cnt);
        n_checks++; if (STICKY_INVALID !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins: got %b expected 1", STICKY_INVALID); end
        n_checks++; if (STICKY_OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL sticky_ovf_cleared: got %b expected 0", STICKY_OVERFLOW); end
        n_checks++; if (ERR_COUNT !== 8'(exp_err)) begin n_fail++; $display("FAIL sticky_err_inc: got %0d expected %0d", ERR_COUNT, exp_err); end
        n_checks++; if (!pop || !have || head() !== e) begin n_fail++; $display("FAIL sticky_div_entry: got %0h expected %0h", head(), e); end
        tick();
        CLR_STICKY = 0;
        sample(push, pop, have, e, cnt);
        n_checks++; if (STICKY_INVALID !== 1'b0) begin n_fail++; $display("FAIL sticky_clear: got %b expected 0", STICKY_INVALID); end
        n_checks++; if (ERR_COUNT !== 8'd2) begin n_fail++; $display("FAIL sticky_err_kept: got %0d expected 2", ERR_COUNT); end
        OUT_READY = 0;
        tick();
    endtask

    task automatic test_saturate();
        OUT_READY_b = 1;
        for (int i = 0; i < 5; i++) begin
            IN_VALID_b = 1; FUNC_CODE_b = OP_ADD; VALUE0_b = 16'(i); OVERFLOW_b = 1;
            @(negedge CLK);
            n_checks++; if (ERR_COUNT_b !== 2'((i < 3) ? i : 3)) begin n_fail++; $display("FAIL sat_count_%0d: got %0d expected %0d", i, ERR_COUNT_b, (i < 3) ? i : 3); end
            tick();
        end
        IN_VALID_b = 0; OVERFLOW_b = 0;
        @(negedge CLK);
        n_checks++; if (ERR_COUNT_b !== 2'd3) begin n_fail++; $display("FAIL sat_hold: got %0d expected 3", ERR_COUNT_b); end
        OUT_READY_b = 0;
        tick();
    endtask

    task automatic test_mid_reset();
        bit push, pop, have; alu_entry_t e; int cnt;
        OUT_READY = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, OP_ADD, 16'h0000, 16'(16'h00a0 + i), 0, 0);
            sample(push, pop, have, e, cnt);
            tick();
        end
        drive(0, 4'h0, 16'h0, 16'h0, 0, 0);
        sample(push, pop, have, e, cnt);
        n_checks++; if (COUNT !== CW'(3)) begin n_fail++; $display("FAIL mrst_pre_count: got %0d expected 3", COUNT); end
        #2 RST_N = 1'b0;
        #1;
        exp_q.delete();
        exp_err = 0;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL mrst_out_valid: got %b expected 0", OUT_VALID); end
        n_checks++; if (COUNT !== '0) begin n_fail++; $display("FAIL mrst_count: got %0d expected 0", COUNT); end
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL mrst_in_ready: got %b expected 1", IN_READY); end
        n_checks++; if (OUT_VALUE0 !== 16'h0) begin n_fail++; $display("FAIL mrst_out_data: got %h expected 0000", OUT_VALUE0); end
        tick();
        RST_N = 1'b1;
        drive(1, OP_SUB, 16'h00ff, 16'h1234, 0, 0);
        sample(push, pop, have, e, cnt);
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL mrst_no_bypass: got %b expected 0", OUT_VALID); end
        tick();
        drive(0, 4'h0, 16'h0, 16'h0, 0, 0);
        OUT_READY = 1;
        sample(push, pop, have, e, cnt);
        n_checks++; if (OUT_VALUE0 !== 16'h1234 || OUT_FUNC_CODE !== 4'b1110) begin n_fail++; $display("FAIL mrst_first_push: got %b/%h expected 1110/1234", OUT_FUNC_CODE, OUT_VALUE0); end
        n_checks++; if (!pop || !have || head() !== e) begin n_fail++; $display("FAIL mrst_first_entry: got %0h expected %0h", head(), e); end
        tick();
        OUT_READY = 0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_fill();
        test_back_to_back();
        test_sticky();
        test_saturate();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
